// File: rtl/trace_capture_if.sv
// Request/response bus between the control-request decoder and trace_capture.
// The decoder side is the master; trace_capture is the slave.
interface trace_capture_if;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  bRequest;
  logic [15:0] wValue;
  logic        resp_valid;
  logic        resp_last;
  logic [15:0] parameter_Block16;

  modport master (
    output req_valid,
    output bRequest,
    output wValue,
    input  req_ready,
    input  resp_valid,
    input  resp_last,
    input  parameter_Block16
  );

  modport slave (
    input  req_valid,
    input  bRequest,
    input  wValue,
    output req_ready,
    output resp_valid,
    output resp_last,
    output parameter_Block16
  );
endinterface

// File: rtl/trace_capture.sv
// Probe-bit trace capture: SET selects a probe bit and records DEPTH samples of it,
// GET returns a status word followed by the packed samples, one 16-bit word per cycle.
module trace_capture #(
  parameter int unsigned PROBE_W = 256,
  parameter int unsigned SEL_W   = 8,
  parameter int unsigned DEPTH   = 32,
  parameter logic [7:0]  REQ_SET = 8'h06,
  parameter logic [7:0]  REQ_GET = 8'h86
) (
  input  logic               clk,
  input  logic               reset,
  trace_capture_if.slave     bus,
  input  logic [PROBE_W-1:0] d,
  output logic               q,
  output logic [SEL_W-1:0]   actual_select,
  output logic               busy
);

  localparam int unsigned NWORDS = DEPTH / 16;
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
  localparam int unsigned WRD_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;
  localparam logic [1:0] READ    = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [1:0]       ret_q, ret_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WRD_W-1:0] word_q, word_d;
  logic [DEPTH-1:0] buf_q, buf_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             q_q, q_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_last_q, resp_last_d;
  logic [15:0]      resp_data_q, resp_data_d;

  logic             accept;
  logic [15:0]      status;
  int unsigned      rd_base;

  // Handshake and status outputs decoded from the current state
  always_comb begin
    bus.req_ready = (state_q == IDLE) || (state_q == DONE);
    busy          = (state_q == CAPTURE) || (state_q == READ);
    accept        = bus.req_valid && bus.req_ready;
    status        = {err_q, done_q, 1'b0, 13'(sel_q)};
    actual_select = sel_q;
    q             = q_q;
    bus.resp_valid        = resp_valid_q;
    bus.resp_last         = resp_last_q;
    bus.parameter_Block16 = resp_data_q;
  end

  // Next-state logic for the request FSM, capture buffer and response words
  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    cnt_d        = cnt_q;
    word_d       = word_q;
    buf_d        = buf_q;
    sel_d        = sel_q;
    err_d        = err_q;
    done_d       = done_q;
    q_d          = d[sel_q];
    // Response outputs are zero unless a word is being driven next cycle
    resp_valid_d = 1'b0;
    resp_last_d  = 1'b0;
    resp_data_d  = 16'h0000;
    rd_base      = 16 * 32'(word_q);

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          if (bus.bRequest == REQ_SET) begin
            if (32'(bus.wValue) < PROBE_W) begin
              sel_d   = bus.wValue[SEL_W-1:0];
              err_d   = 1'b0;
              done_d  = 1'b0;
              cnt_d   = '0;
              state_d = CAPTURE;
            end else begin
              // Out-of-range select only flags the error; the old capture survives
              err_d = 1'b1;
            end
          end else if (bus.bRequest == REQ_GET) begin
            ret_d        = state_q;
            word_d       = '0;
            state_d      = READ;
            resp_valid_d = 1'b1;
            resp_data_d  = status;
            // No valid samples from IDLE, so the status word is the whole reply
            resp_last_d  = (state_q == IDLE);
          end
          // Any other code is consumed without effect
        end
      end

      CAPTURE: begin
        buf_d[cnt_q[CNT_W-2:0]] = d[sel_q];
        cnt_d                   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DEPTH - 1)) begin
          done_d  = 1'b1;
          state_d = DONE;
        end
      end

      READ: begin
        if (resp_last_q) begin
          // Final word has been presented; go back where the GET came from
          state_d = ret_q;
        end else begin
          resp_valid_d = 1'b1;
          resp_data_d  = buf_q[rd_base +: 16];
          resp_last_d  = (word_q == WRD_W'(NWORDS - 1));
          word_d       = word_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ret_q        <= IDLE;
      cnt_q        <= '0;
      word_q       <= '0;
      buf_q        <= '0;
      sel_q        <= '0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      q_q          <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_last_q  <= 1'b0;
      resp_data_q  <= 16'h0000;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      buf_q        <= buf_d;
      sel_q        <= sel_d;
      err_q        <= err_d;
      done_q       <= done_d;
      q_q          <= q_d;
      resp_valid_q <= resp_valid_d;
      resp_last_q  <= resp_last_d;
      resp_data_q  <= resp_data_d;
    end
  end

endmodule

// File: tb/tb_trace_capture.sv
// Randomised bench for trace_capture against a transaction-level reference model.
module tb_trace_capture;

  localparam int unsigned PROBE_W = 256;
  localparam int unsigned SEL_W   = 8;
  localparam int unsigned DEPTH   = 32;
  localparam int unsigned NW      = DEPTH / 16;
  localparam logic [7:0]  REQ_SET = 8'h06;
  localparam logic [7:0]  REQ_GET = 8'h86;

  logic               clk = 1'b0;
  logic               reset;
  logic [PROBE_W-1:0] d;
  logic               q;
  logic [SEL_W-1:0]   actual_select;
  logic               busy;

  trace_capture_if bus ();

  trace_capture #(
    .PROBE_W (PROBE_W),
    .SEL_W   (SEL_W),
    .DEPTH   (DEPTH),
    .REQ_SET (REQ_SET),
    .REQ_GET (REQ_GET)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .d             (d),
    .q             (q),
    .actual_select (actual_select),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Reference model state
  int unsigned m_sel;
  bit          m_err;
  bit          m_done;
  bit          m_samp [DEPTH];

  int checks = 0;
  int errors = 0;
  logic [15:0] last_words [$];
  logic [15:0] first_words [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PROBE_W-1:0] rand_d();
    logic [PROBE_W-1:0] r;
    for (int i = 0; i < PROBE_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One clock; q must show the probe bit selected before the edge
  task automatic tick();
    logic exp_q;
    exp_q = d[m_sel];
    @(posedge clk);
    #1;
    check("q_live", q, exp_q);
  endtask

  task automatic model_reset();
    m_sel  = 0;
    m_err  = 0;
    m_done = 0;
    for (int i = 0; i < DEPTH; i++) m_samp[i] = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ready"}, bus.req_ready, 1);
    check({tag, "_rvalid"}, bus.resp_valid, 0);
    check({tag, "_rlast"}, bus.resp_last, 0);
    check({tag, "_rdata"}, bus.parameter_Block16, 0);
  endtask

  task automatic issue(input logic [7:0] code, input logic [15:0] w);
    check("ready_at_req", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.bRequest  = code;
    bus.wValue    = w;
    d             = rand_d();
    tick();
    bus.req_valid = 1'b0;
    bus.bRequest  = 8'h00;
  endtask

  // Asynchronous reset pulse; outputs must clear without waiting for an edge
  task automatic reset_now();
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_q", q, 0);
    check("rst_sel", actual_select, 0);
    check_idle_outputs("rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    d = rand_d();
    tick();
  endtask

  // mode 0: random d; mode 1: d[sel] alternates 1,0,...; mode 2: requests injected mid-capture
  task automatic do_set(input logic [15:0] w, input int mode, input int abort_at);
    issue(REQ_SET, w);
    if (32'(w) >= PROBE_W) begin
      m_err = 1;
      check("bad_sel_kept", actual_select, m_sel);
      check("bad_busy", busy, 0);
      check("bad_ready", bus.req_ready, 1);
      return;
    end
    m_sel  = w;
    m_err  = 0;
    m_done = 0;
    check("sel", actual_select, m_sel);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == abort_at) begin
        reset_now();
        return;
      end
      check("cap_busy", busy, 1);
      check("cap_ready", bus.req_ready, 0);
      d = rand_d();
      if (mode == 1) d[m_sel] = (i % 2 == 0);
      bus.req_valid = 1'b0;
      if (mode == 2 && i == 3) begin
        bus.req_valid = 1'b1;
        bus.bRequest  = REQ_SET;
        bus.wValue    = 16'd9;
      end
      if (mode == 2 && i == 4) begin
        bus.req_valid = 1'b1;
        bus.bRequest  = REQ_GET;
      end
      m_samp[i] = d[m_sel];
      tick();
    end
    bus.req_valid = 1'b0;
    m_done = 1;
    check("cap_end_sel", actual_select, m_sel);
    check("cap_end_busy", busy, 0);
    check("cap_end_ready", bus.req_ready, 1);
  endtask

  task automatic do_get();
    logic [15:0] exp [$];
    logic [15:0] w;
    exp.push_back({m_err, m_done, 1'b0, 13'(m_sel)});
    if (m_done) begin
      for (int k = 0; k < NW; k++) begin
        for (int b = 0; b < 16; b++) w[b] = m_samp[16 * k + b];
        exp.push_back(w);
      end
    end
    issue(REQ_GET, 16'($urandom));
    last_words.delete();
    for (int k = 0; k < exp.size(); k++) begin
      check("get_valid", bus.resp_valid, 1);
      check("get_word", bus.parameter_Block16, exp[k]);
      check("get_last", bus.resp_last, (k == exp.size() - 1));
      check("get_busy", busy, 1);
      check("get_ready", bus.req_ready, 0);
      last_words.push_back(bus.parameter_Block16);
      d = rand_d();
      tick();
    end
    check_idle_outputs("get_end");
  endtask

  initial begin
    logic [7:0] code;
    int r;
    reset         = 1'b1;
    d             = '0;
    bus.req_valid = 1'b0;
    bus.bRequest  = 8'h00;
    bus.wValue    = 16'h0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("init_q", q, 0);
    check("init_sel", actual_select, 0);
    check_idle_outputs("init");
    reset = 1'b0;
    d = rand_d();
    tick();

    // GET before any capture
    do_get();
    check("pre_cnt", last_words.size(), 1);
    check("pre_word", last_words[0], 16'h0000);

    // Out-of-range select from IDLE
    do_set(16'd300, 0, DEPTH);
    check("oor_sel", actual_select, 0);
    do_get();
    check("oor_cnt", last_words.size(), 1);
    check("oor_word", last_words[0], 16'h8000);

    // Select 5, alternating pattern
    do_set(16'd5, 1, DEPTH);
    do_get();
    check("alt_cnt", last_words.size(), 3);
    check("alt_w0", last_words[0], 16'h4005);
    check("alt_w1", last_words[1], 16'h5555);
    check("alt_w2", last_words[2], 16'h5555);

    // Requests during capture are ignored
    do_set(16'd2, 2, DEPTH);
    do_get();
    check("ign_w0", last_words[0], 16'h4002);

    // Reset mid-capture
    do_set(16'd11, 0, 10);
    do_get();
    check("rst_cnt", last_words.size(), 1);
    check("rst_word", last_words[0], 16'h0000);

    // Re-read returns identical data
    do_set(16'd7, 0, DEPTH);
    do_get();
    first_words = last_words;
    do_get();
    check("reread_cnt", last_words.size(), first_words.size());
    for (int k = 0; k < first_words.size() && k < last_words.size(); k++)
      check("reread_word", last_words[k], first_words[k]);

    // Random mix of operations
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 2) begin
        do_set(16'($urandom_range(0, 299)), 0, (r == 0) ? $urandom_range(0, DEPTH - 1) : DEPTH);
      end else if (r <= 5) begin
        do_get();
      end else if (r == 6) begin
        code = 8'($urandom);
        if (code == REQ_SET || code == REQ_GET) code = 8'h01;
        issue(code, 16'($urandom));
        check("unk_sel", actual_select, m_sel);
        check_idle_outputs("unk");
      end else begin
        d = rand_d();
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
